// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit_if
// Purpose  : Bundles the instruction-memory bus, the redirect request and the
//            instruction stream between the fetch unit and its neighbours.
// Revision : 1.0  initial release
// ============================================================================
interface instr_fetch_unit_if #(
  parameter int DATA_WIDTH = 16
);
  logic                    mem_req;
  logic [DATA_WIDTH-1:0]   mem_addr;
  logic                    mem_gnt;
  logic                    mem_rvalid;
  logic [2*DATA_WIDTH-1:0] mem_rdata;
  logic                    redirect_valid;
  logic [DATA_WIDTH-1:0]   redirect_pc;
  logic                    instr_valid;
  logic                    instr_ready;
  logic [DATA_WIDTH-1:0]   instr_opcode;
  logic [DATA_WIDTH-1:0]   instr_operand;
  logic [DATA_WIDTH-1:0]   instr_pc;

  // master: the fetch unit; slave: memory, redirect source and consumer
  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata,
    input  redirect_valid, redirect_pc,
    output instr_valid, instr_opcode, instr_operand, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata,
    output redirect_valid, redirect_pc,
    input  instr_valid, instr_opcode, instr_operand, instr_pc,
    output instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : In-order instruction fetch with credit-limited issue, a response
//            FIFO and redirect flush. Optional IFETCH_PERF_EN adds stall and
//            flush performance counters.
// Revision : 1.0  initial release
// ============================================================================
module instr_fetch_unit #(
  parameter int DATA_WIDTH      = 16,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  instr_fetch_unit_if.master bus
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]        perf_stall_cycles,
  output logic [15:0]        perf_flush_count
`endif
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
  localparam int c_ent_w = 3 * DATA_WIDTH;
  localparam logic [c_cnt_w:0]   c_depth   = (c_cnt_w + 1)'(FIFO_DEPTH);
  localparam logic [c_cnt_w-1:0] c_max_out = c_cnt_w'(MAX_OUTSTANDING);

  logic                  r_active;
  logic [DATA_WIDTH-1:0] r_fetch_addr;
  logic [DATA_WIDTH-1:0] r_resp_pc;
  logic [c_cnt_w-1:0]    r_outstanding;
  logic [c_cnt_w-1:0]    r_drop_cnt;
  logic [c_cnt_w-1:0]    r_count;
  logic [c_ptr_w-1:0]    r_wr_ptr;
  logic [c_ptr_w-1:0]    r_rd_ptr;
  logic [c_ent_w-1:0]    r_fifo_mem [FIFO_DEPTH];
  logic [c_ent_w-1:0]    r_last;

  logic                  w_credit;
  logic                  w_req;
  logic                  w_gnt;
  logic                  w_rsp;
  logic                  w_drop;
  logic                  w_push;
  logic                  w_valid;
  logic                  w_pop;
  logic [c_ent_w-1:0]    w_head;
  logic [c_ent_w-1:0]    w_out;
  logic [c_cnt_w-1:0]    w_outstanding_nxt;
  logic [c_cnt_w-1:0]    w_count_nxt;

  // Outstanding reads hold FIFO slots in reserve so a push always has room.
  assign w_credit = (r_outstanding < c_max_out) &&
                    (({1'b0, r_outstanding} + {1'b0, r_count}) < c_depth);
  assign w_req    = r_active & ~bus.redirect_valid & w_credit;
  assign w_gnt    = w_req & bus.mem_gnt;
  assign w_rsp    = bus.mem_rvalid & (r_outstanding != '0);
  assign w_drop   = w_rsp & (r_drop_cnt != '0);
  assign w_push   = w_rsp & ~w_drop & ~bus.redirect_valid;
  assign w_valid  = (r_count != '0);
  assign w_pop    = w_valid & bus.instr_ready & ~bus.redirect_valid;
  assign w_head   = r_fifo_mem[r_rd_ptr];
  assign w_out    = w_valid ? w_head : r_last;

  assign bus.mem_req       = w_req;
  assign bus.mem_addr      = r_fetch_addr;
  assign bus.instr_valid   = w_valid;
  assign bus.instr_opcode  = w_out[c_ent_w-1 -: DATA_WIDTH];
  assign bus.instr_operand = w_out[2*DATA_WIDTH-1 -: DATA_WIDTH];
  assign bus.instr_pc      = w_out[DATA_WIDTH-1:0];

  always_comb begin
    w_outstanding_nxt = r_outstanding;
    case ({w_gnt, w_rsp})
      2'b10:   w_outstanding_nxt = r_outstanding + c_cnt_w'(1);
      2'b01:   w_outstanding_nxt = r_outstanding - c_cnt_w'(1);
      default: w_outstanding_nxt = r_outstanding;
    endcase
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + c_cnt_w'(1);
      2'b01:   w_count_nxt = r_count - c_cnt_w'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_active      <= 1'b0;
      r_fetch_addr  <= '0;
      r_resp_pc     <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_last        <= '0;
    end else begin
      r_active      <= 1'b1;
      r_outstanding <= w_outstanding_nxt;
      if (w_valid) begin
        r_last <= w_head;
      end
      if (bus.redirect_valid) begin
        // Everything still in flight belongs to the abandoned path.
        r_fetch_addr <= bus.redirect_pc;
        r_resp_pc    <= bus.redirect_pc;
        r_drop_cnt   <= r_outstanding - c_cnt_w'(w_rsp);
        r_count      <= '0;
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
      end else begin
        r_count <= w_count_nxt;
        if (w_gnt) begin
          r_fetch_addr <= r_fetch_addr + 1'b1;
        end
        if (w_drop) begin
          r_drop_cnt <= r_drop_cnt - c_cnt_w'(1);
        end
        if (w_push) begin
          r_wr_ptr  <= r_wr_ptr + 1'b1;
          r_resp_pc <= r_resp_pc + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= {bus.mem_rdata, r_resp_pc};
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_cycles <= '0;
      perf_flush_count  <= '0;
    end else begin
      if (bus.instr_ready && !w_valid && (perf_stall_cycles != '1)) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
      if (bus.redirect_valid && (perf_flush_count != '1)) begin
        perf_flush_count <= perf_flush_count + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Directed and randomized bench for instr_fetch_unit with a memory
//            responder and an in-order instruction stream reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch_unit;

  localparam int DW   = 16;
  localparam int MAXO = 2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.DATA_WIDTH(DW)) bus ();

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [15:0] perf_flush_count;
`endif

  instr_fetch_unit #(
    .DATA_WIDTH      (DW),
    .FIFO_DEPTH      (4),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .bus               (bus)
`ifdef IFETCH_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count)
`endif
  );

  typedef struct {
    logic [15:0] addr;
    int          due;
  } rd_t;

  rd_t         pending[$];
  int          n_tests, n_fail, cyc;
  logic [15:0] exp_fetch, exp_pc, prev_addr;
  bit          prev_wait, seen_valid, force_rv, timed_out;
  int          grant_cnt, first_gnt_cyc, first_valid_cyc, pop_cnt, bubbles;
  int          gnt_mode, lat_mode, lat_fix, stall_left;
  int unsigned stall_m, flush_m;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {16'h1000 + a, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: after reset/redirect the fetch and delivered streams are
  // consecutive addresses from the start point, each carrying mem_word(pc).
  task automatic monitor();
    rd_t e;
    if (!reset_n) begin
      pending.delete();
      exp_fetch = '0; exp_pc = '0; prev_wait = 0; seen_valid = 0;
      grant_cnt = 0; first_gnt_cyc = -1; first_valid_cyc = -1;
      pop_cnt = 0; bubbles = 0; stall_m = 0; flush_m = 0;
      return;
    end
    if (bus.redirect_valid) begin
      chk("req_low_on_redirect", {31'd0, bus.mem_req}, 32'd0);
      exp_fetch = bus.redirect_pc;
      prev_wait = 0;
    end else begin
      if (prev_wait) begin
        chk("req_held", {31'd0, bus.mem_req}, 32'd1);
        chk("addr_held", {16'd0, bus.mem_addr}, {16'd0, prev_addr});
      end
      if (bus.mem_req && bus.mem_gnt) begin
        chk("grant_addr", {16'd0, bus.mem_addr}, {16'd0, exp_fetch});
        e.addr = bus.mem_addr;
        e.due  = cyc + ((lat_mode == 0) ? lat_fix : int'($urandom_range(1, 3)));
        pending.push_back(e);
        chk("outstanding_le_max", {31'd0, pending.size() <= MAXO}, 32'd1);
        exp_fetch++;
        if (grant_cnt == 0) first_gnt_cyc = cyc;
        grant_cnt++;
      end
      prev_wait = bus.mem_req && !bus.mem_gnt;
      prev_addr = bus.mem_addr;
    end
    if (bus.instr_ready && !bus.instr_valid) stall_m++;
    if (bus.redirect_valid) flush_m++;
    if (bus.instr_valid && !seen_valid) begin
      seen_valid = 1;
      first_valid_cyc = cyc;
    end
    if (seen_valid && bus.instr_ready && !bus.instr_valid && !bus.redirect_valid) bubbles++;
    if (bus.redirect_valid) begin
      exp_pc = bus.redirect_pc;
    end else if (bus.instr_valid && bus.instr_ready) begin
      chk("instr_pc", {16'd0, bus.instr_pc}, {16'd0, exp_pc});
      chk("instr_opcode", {16'd0, bus.instr_opcode}, {16'd0, 16'h1000 + exp_pc});
      chk("instr_operand", {16'd0, bus.instr_operand}, {16'd0, exp_pc});
      exp_pc++;
      pop_cnt++;
    end
  endtask

  task automatic drive_mem();
    rd_t e;
    case (gnt_mode)
      0: bus.mem_gnt = 1'b1;
      1: begin
        if (stall_left > 0) begin
          bus.mem_gnt = 1'b0;
          stall_left--;
        end else if ($urandom_range(0, 4) == 0) begin
          bus.mem_gnt = 1'b0;
          stall_left = 2;
        end else begin
          bus.mem_gnt = 1'b1;
        end
      end
      default: bus.mem_gnt = 1'b0;
    endcase
    if (reset_n && pending.size() > 0 && pending[0].due <= cyc + 1) begin
      e = pending.pop_front();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = mem_word(e.addr);
    end else begin
      bus.mem_rvalid = force_rv;
      bus.mem_rdata  = force_rv ? 32'hDEAD_BEEF : $urandom;
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    monitor();
    @(posedge clk);
    #1;
    drive_mem();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_mem_req"}, {31'd0, bus.mem_req}, 32'd0);
    chk({tag, "_mem_addr"}, {16'd0, bus.mem_addr}, 32'd0);
    chk({tag, "_instr_valid"}, {31'd0, bus.instr_valid}, 32'd0);
    chk({tag, "_opcode"}, {16'd0, bus.instr_opcode}, 32'd0);
    chk({tag, "_operand"}, {16'd0, bus.instr_operand}, 32'd0);
    chk({tag, "_pc"}, {16'd0, bus.instr_pc}, 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    timed_out = 1;
    for (int i = 0; i < 40; i++) begin
      if (bus.instr_valid) begin
        timed_out = 0;
        break;
      end
      step();
    end
    chk(tag, {31'd0, timed_out}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    gnt_mode = 0; lat_mode = 0; lat_fix = 1; stall_left = 0; force_rv = 0;
    reset_n = 1'b0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.instr_ready = 1'b0;

    // Reset state
    repeat (3) step();
    chk_outputs_zero("reset");

    // Streaming: latency and one instruction per cycle
    reset_n = 1'b1;
    bus.instr_ready = 1'b1;
    repeat (40) step();
    chk("first_latency", first_valid_cyc - first_gnt_cyc, 32'd2);
    chk("stream_bubbles", bubbles, 32'd0);
    chk("stream_pops", {31'd0, pop_cnt >= 30}, 32'd1);

    // Back-pressure: fill exactly FIFO depth, then drain in order
    bus.instr_ready = 1'b0;
    do_reset();
    repeat (12) step();
    chk("full_grants", grant_cnt, 32'd4);
    chk("full_req_low", {31'd0, bus.mem_req}, 32'd0);
    chk("full_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("full_head_pc", {16'd0, bus.instr_pc}, 32'd0);
    bus.instr_ready = 1'b1;
    repeat (20) step();
    chk("drain_pops", {31'd0, pop_cnt >= 12}, 32'd1);

    // Redirect with two reads outstanding
    do_reset();
    lat_fix = 3;
    timed_out = 1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (grant_cnt >= 6 && pending.size() == 2) begin
        timed_out = 0;
        break;
      end
    end
    chk("two_outstanding_timeout", {31'd0, timed_out}, 32'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 16'h0040;
    step();
    bus.redirect_valid = 1'b0;
    wait_valid("redir_valid_timeout");
    chk("redir_pc", {16'd0, bus.instr_pc}, 32'h0040);
    chk("redir_opcode", {16'd0, bus.instr_opcode}, 32'h1040);
    chk("redir_operand", {16'd0, bus.instr_operand}, 32'h0040);
    repeat (20) step();

    // Redirect coinciding with rvalid and pop, target wraps
    lat_fix = 1;
    bus.instr_ready = 1'b0;
    do_reset();
    repeat (10) step();
    bus.instr_ready = 1'b1;
    timed_out = 1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (bus.mem_rvalid && bus.instr_valid) begin
        timed_out = 0;
        break;
      end
    end
    chk("coincide_timeout", {31'd0, timed_out}, 32'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 16'hFFFF;
    step();
    bus.redirect_valid = 1'b0;
    chk("flush_empty", {31'd0, bus.instr_valid}, 32'd0);
    wait_valid("wrap_valid_timeout");
    chk("wrap_pc_ffff", {16'd0, bus.instr_pc}, 32'h0000_FFFF);
    step();
    chk("wrap_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("wrap_pc_0000", {16'd0, bus.instr_pc}, 32'd0);
    repeat (10) step();

    // Random grant stalls, latency, back-pressure and redirects
    do_reset();
    gnt_mode = 1;
    lat_mode = 1;
    for (int i = 0; i < 400; i++) begin
      step();
      bus.instr_ready    = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 39) == 0);
      bus.redirect_pc    = 16'($urandom);
    end
    bus.redirect_valid = 1'b0;
    bus.instr_ready = 1'b1;
    gnt_mode = 0;
    lat_mode = 0;
    repeat (20) step();

    // Asynchronous reset mid-stream, stray response afterwards
    repeat (10) step();
    #2;
    reset_n = 1'b0;
    #1;
    chk_outputs_zero("async_reset");
    step();
    step();
    gnt_mode = 2;
    reset_n = 1'b1;
    force_rv = 1;
    step();
    force_rv = 0;
    repeat (4) step();
    chk("stray_rvalid_ignored", {31'd0, bus.instr_valid}, 32'd0);
    chk("req_after_reset", {31'd0, bus.mem_req}, 32'd1);
    gnt_mode = 0;
    for (int i = 0; i < 3; i++) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 16'($urandom);
      step();
      bus.redirect_valid = 1'b0;
      repeat (6) step();
    end
`ifdef IFETCH_PERF_EN
    chk("perf_flush_count", {16'd0, perf_flush_count}, 32'd3);
    chk("perf_stall_cycles", perf_stall_cycles, stall_m);
`endif
    chk("post_redirect_pops", {31'd0, pop_cnt > 0}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
